// File: rtl/mmio_input_reader.sv
// -----------------------------------------------------------------------------
// mmio_input_reader
//
// Input-side memory-mapped peripheral for the MIPS board top. Slide switches
// and push-buttons are synchronised (two flops), debounced per bit, and exposed
// to the processor through a 16-byte read-only register window. Button presses
// (stable 0->1) latch into a pending register and bump a saturating 16-bit
// press counter. irq stays high while any pending flag is set.
//
// Register map (word offset rd_addr[3:2], unused upper bits read 0):
//   0x0 SW   debounced switch levels
//   0x4 BTN  debounced button levels
//   0x8 PEND pending press flags, read-to-clear
//   0xC CNT  saturating press count
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   sw_raw    raw switch levels (asynchronous)
//   btn_raw   raw button levels, 1 = pressed (asynchronous)
//   rd_en     read strobe, sampled at the clk rising edge
//   rd_addr   byte address of the read
//   rd_data   read data, 0 unless rd_valid
//   rd_valid  one-cycle pulse the cycle after an accepted read
//   irq       registered, high while any pending bit is set
//
// Read handshake: there is no back-pressure. A read is accepted on any edge
// where rd_en=1 and rd_addr[31:4] matches the window. Exactly one edge later
// rd_valid=1 for one cycle with the register value as it stood at the
// accepting edge; every other cycle gives rd_valid=0 and rd_data=0. Reads may
// be issued on consecutive cycles and return one result per cycle.
// -----------------------------------------------------------------------------
module mmio_input_reader #(
    parameter int          N_SW      = 16,
    parameter int          N_BTN     = 4,
    parameter int          DB_CYCLES = 50000,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SW-1:0]  sw_raw,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             rd_en,
    input  logic [31:0]      rd_addr,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    output logic             irq
);

    // Switches and buttons share one debounce datapath: buttons sit on top.
    localparam int              N_IN    = N_SW + N_BTN;
    localparam int              CW      = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]   DB_LAST = CW'(DB_CYCLES - 1);

    logic [N_IN-1:0]  raw_all;
    logic [N_IN-1:0]  sync1;
    logic [N_IN-1:0]  sync2;
    logic [N_IN-1:0]  stable;
    logic [N_IN-1:0]  stable_next;
    logic [CW-1:0]    db_cnt      [N_IN];
    logic [CW-1:0]    db_cnt_next [N_IN];

    logic [N_SW-1:0]  sw_stable;
    logic [N_BTN-1:0] btn_stable;
    logic [N_BTN-1:0] btn_stable_next;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] pending_next;
    logic [15:0]      press_count;
    logic [15:0]      count_next;
    logic [16:0]      count_sum;
    logic [5:0]       press_pop;

    logic             accept;
    logic             pend_clr;
    logic [31:0]      rd_word;
    logic             unused_addr_bits;

    assign raw_all = {btn_raw, sw_raw};

    // Byte lane bits do not participate in the decode.
    assign unused_addr_bits = ^rd_addr[1:0];

    function automatic logic [5:0] popcount(input logic [N_BTN-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < N_BTN; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

    // Debounce: the counter runs while synced differs from stable and is
    // cleared the moment they agree again, so only an uninterrupted run of
    // DB_CYCLES differing cycles moves the stable level.
    always_comb begin
        stable_next = stable;
        for (int i = 0; i < N_IN; i++) begin
            db_cnt_next[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    stable_next[i] = sync2[i];
                end else begin
                    db_cnt_next[i] = db_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign sw_stable       = stable[N_SW-1:0];
    assign btn_stable      = stable[N_IN-1:N_SW];
    assign btn_stable_next = stable_next[N_IN-1:N_SW];

    // A press is detected on the same edge that the stable level rises, so
    // pending and the count update together with the BTN register.
    assign press     = btn_stable_next & ~btn_stable;
    assign press_pop = popcount(press);
    assign count_sum = {1'b0, press_count} + 17'(press_pop);
    assign count_next = count_sum[16] ? 16'hFFFF : count_sum[15:0];

    assign accept   = rd_en && (rd_addr[31:4] == BASE_ADDR[31:4]);
    assign pend_clr = accept && (rd_addr[3:2] == 2'd2);

    // Read-to-clear drops every bit returned; a press on the same edge is
    // OR-ed in afterwards so it survives for the next read.
    assign pending_next = (pend_clr ? '0 : pending) | press;

    always_comb begin
        rd_word = '0;
        case (rd_addr[3:2])
            2'd0:    rd_word[N_SW-1:0]  = sw_stable;
            2'd1:    rd_word[N_BTN-1:0] = btn_stable;
            2'd2:    rd_word[N_BTN-1:0] = pending;
            default: rd_word[15:0]      = press_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1       <= '0;
            sync2       <= '0;
            stable      <= '0;
            for (int i = 0; i < N_IN; i++) begin
                db_cnt[i] <= '0;
            end
            pending     <= '0;
            press_count <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            irq         <= 1'b0;
        end else begin
            sync1       <= raw_all;
            sync2       <= sync1;
            stable      <= stable_next;
            for (int i = 0; i < N_IN; i++) begin
                db_cnt[i] <= db_cnt_next[i];
            end
            pending     <= pending_next;
            // Assigned every cycle (adding zero when idle) so the count
            // always reflects the current value plus new presses.
            press_count <= count_next;
            rd_data     <= accept ? rd_word : 32'd0;
            rd_valid    <= accept;
            irq         <= |pending;
        end
    end

endmodule
